// File: rtl/enc_pkg.sv
// Shared states, frame constants and byte-forming helpers for the message
// encryption stream.
package enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_MSG  = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int FRAME_LEN = 64;
  localparam int MAX_MSG   = 54;

  localparam logic [6:0] PAD_CHAR = 7'h20;
  localparam logic [4:0] PRE_MIN  = 5'd10;
  localparam logic [4:0] PRE_MAX  = 5'd26;

  // Feedback masks known to give the full 127-state sequence
  localparam logic [6:0] TAP_60 = 7'h60;
  localparam logic [6:0] TAP_48 = 7'h48;
  localparam logic [6:0] TAP_78 = 7'h78;
  localparam logic [6:0] TAP_72 = 7'h72;
  localparam logic [6:0] TAP_6A = 7'h6A;
  localparam logic [6:0] TAP_69 = 7'h69;
  localparam logic [6:0] TAP_5C = 7'h5C;
  localparam logic [6:0] TAP_7E = 7'h7E;
  localparam logic [6:0] TAP_7B = 7'h7B;

  function automatic logic [4:0] clamp_pre(input logic [4:0] len);
    logic [4:0] r;
    if (len < PRE_MIN) begin
      r = PRE_MIN;
    end else if (len > PRE_MAX) begin
      r = PRE_MAX;
    end else begin
      r = len;
    end
    return r;
  endfunction

  // An all-zero LFSR would lock up, so zero seeds start from 0x01
  function automatic logic [6:0] fix_seed(input logic [6:0] seed);
    logic [6:0] r;
    if (seed == 7'h00) begin
      r = 7'h01;
    end else begin
      r = seed;
    end
    return r;
  endfunction

  function automatic logic [7:0] enc_byte(input logic [6:0] plain, input logic [6:0] key);
    logic [6:0] c;
    c = plain ^ key;
    return {^c, c};
  endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR with loadable seed and tap mask; next_state is
// exposed so a byte loaded on the stepping edge can use the advanced key.
module lfsr7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic [6:0] taps,
  input  logic       step,
  output logic [6:0] state,
  output logic [6:0] next_state
);

  logic [6:0] state_r;
  logic [6:0] taps_r;

  assign state      = state_r;
  assign next_state = {state_r[5:0], ^(state_r & taps_r)};

  // Seed/tap capture on frame launch, one shift per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= 7'h01;
      taps_r  <= 7'h00;
    end else if (load) begin
      state_r <= seed;
      taps_r  <= taps;
    end else if (step) begin
      state_r <= next_state;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/msg_encrypt_stream.sv
// Frames a message into FRAME_LEN parity-tagged bytes (pad, message, pad),
// each XORed with a 7-bit LFSR keystream advanced once per output handshake.
module msg_encrypt_stream
  import enc_pkg::*;
#(
  parameter int FRAME_LEN = enc_pkg::FRAME_LEN,
  parameter int MAX_MSG   = enc_pkg::MAX_MSG
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [4:0] PreLen,
  input  logic [6:0] TapPtrn,
  input  logic [6:0] LfsrInit,
  input  logic       InValid,
  input  logic [7:0] InData,
  input  logic       InLast,
  output logic       InReady,
  output logic       OutValid,
  output logic [7:0] OutData,
  input  logic       OutReady,
  output logic       Ack,
  output logic       Busy
);

  localparam logic [5:0] POS_LAST = 6'(FRAME_LEN - 1);
  localparam logic [5:0] MSG_LAST = 6'(MAX_MSG - 1);

  state_e     state_r;
  logic       out_valid_r;
  logic [7:0] out_data_r;
  logic       ack_r;
  logic [5:0] pos_r;
  logic [5:0] msg_cnt_r;
  logic [4:0] pre_len_r;
  logic       final_r;

  logic       out_hs_s;
  logic       slot_free_s;
  logic       in_ready_s;
  logic       pad_load_s;
  logic       accept_s;
  logic       load_s;
  logic [6:0] plain_s;
  logic [6:0] key_s;
  logic       start_load_s;
  logic [6:0] seed_s;
  logic [6:0] lfsr_state_s;
  logic [6:0] lfsr_next_s;
  logic [5:0] pre_last_s;
  logic       msb_unused_s;

  // Characters are 7-bit; the top bit of InData carries nothing
  assign msb_unused_s = InData[7];

  assign start_load_s = (state_r == ST_IDLE) & Start;
  assign seed_s       = fix_seed(LfsrInit);
  assign pre_last_s   = {1'b0, pre_len_r} - 6'd1;

  lfsr7 u_lfsr (
    .clk        (Clk),
    .rst_n      (Reset),
    .load       (start_load_s),
    .seed       (seed_s),
    .taps       (TapPtrn),
    .step       (out_hs_s),
    .state      (lfsr_state_s),
    .next_state (lfsr_next_s)
  );

  // Handshake qualifiers and the plaintext/key of the byte that may load now
  always_comb begin
    out_hs_s    = out_valid_r & OutReady;
    slot_free_s = ~out_valid_r | OutReady;
    in_ready_s  = 1'b0;
    pad_load_s  = 1'b0;
    plain_s     = PAD_CHAR;
    if (state_r == ST_MSG) begin
      in_ready_s = slot_free_s & ~final_r;
      plain_s    = InData[6:0];
    end else if ((state_r == ST_PRE) || (state_r == ST_POST)) begin
      pad_load_s = slot_free_s & ~final_r;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = in_ready_s & InValid;
    load_s   = pad_load_s | accept_s;
    // A byte loaded on a handshake edge must use the key after that step
    if (out_hs_s) begin
      key_s = lfsr_next_s;
    end else begin
      key_s = lfsr_state_s;
    end
  end

  assign InReady  = in_ready_s;
  assign OutValid = out_valid_r;
  assign OutData  = out_data_r;
  assign Ack      = ack_r;
  assign Busy     = (state_r != ST_IDLE);

  // Frame sequencer and registered output byte
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      ack_r       <= 1'b0;
      pos_r       <= 6'd0;
      msg_cnt_r   <= 6'd0;
      pre_len_r   <= 5'd0;
      final_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pos_r       <= 6'd0;
          msg_cnt_r   <= 6'd0;
          final_r     <= 1'b0;
          ack_r       <= 1'b0;
          out_valid_r <= 1'b0;
          if (Start) begin
            pre_len_r <= clamp_pre(PreLen);
            state_r   <= ST_PRE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PRE, ST_MSG, ST_POST: begin
          if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= enc_byte(plain_s, key_s);
            // The last position is held rather than wrapped
            if (pos_r == POS_LAST) begin
              final_r <= 1'b1;
            end else begin
              pos_r <= pos_r + 6'd1;
            end
            if (accept_s) begin
              msg_cnt_r <= msg_cnt_r + 6'd1;
            end else begin
              msg_cnt_r <= msg_cnt_r;
            end
            if ((state_r == ST_PRE) && (pos_r == pre_last_s)) begin
              state_r <= ST_MSG;
            end else if (accept_s && (InLast || (msg_cnt_r == MSG_LAST))) begin
              state_r <= ST_POST;
            end else begin
              state_r <= state_r;
            end
          end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
            if (final_r) begin
              state_r <= ST_DONE;
              ack_r   <= 1'b1;
            end else begin
              state_r <= state_r;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_DONE: begin
          ack_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_encrypt_stream.sv
// Directed bench for msg_encrypt_stream: a frame-level model predicts all
// FRAME_LEN bytes, and one monitor compares every output handshake against it.
module tb_msg_encrypt_stream;

  localparam int FL = 64;
  localparam int MM = 54;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [4:0] PreLen = 5'd0;
  logic [6:0] TapPtrn = 7'h00;
  logic [6:0] LfsrInit = 7'h00;
  logic       InValid = 1'b0;
  logic [7:0] InData = 8'h00;
  logic       InLast = 1'b0;
  logic       InReady;
  logic       OutValid;
  logic [7:0] OutData;
  logic       OutReady = 1'b0;
  logic       Ack;
  logic       Busy;

  always #5 Clk = ~Clk;

  msg_encrypt_stream #(.FRAME_LEN(FL), .MAX_MSG(MM)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .PreLen(PreLen),
    .TapPtrn(TapPtrn), .LfsrInit(LfsrInit),
    .InValid(InValid), .InData(InData), .InLast(InLast), .InReady(InReady),
    .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady),
    .Ack(Ack), .Busy(Busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b [FL];
  logic [6:0] key_b [FL];
  logic [7:0] got_b [FL];
  logic [7:0] ref_b [FL];
  logic [7:0] msg_b [64];
  int         exp_idx = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [6:0] p, input logic [6:0] k);
    logic [6:0] c;
    c = p ^ k;
    return {^c, c};
  endfunction

  // Number of leading bytes of the captured frame that decrypt to a space
  function automatic int lead_pads();
    int  c;
    bit  run;
    c   = 0;
    run = 1'b1;
    for (int k = 0; k < FL; k++) begin
      if (run && ((got_b[k][6:0] ^ key_b[k]) == 7'h20)) begin
        c++;
      end else begin
        run = 1'b0;
      end
    end
    return c;
  endfunction

  // Compare process: every handshake, stall hold, idle-output rules
  always @(negedge Clk) begin
    if (!Reset || !Busy) begin
      exp_idx <= 0;
    end
    if (!Reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", OutValid, 1);
        chk("hold_data", OutData, prev_data);
      end
      if (OutValid && !OutReady) begin
        chk("stall_inready", InReady, 0);
      end
      if (!Busy || Ack) begin
        chk("idle_inready", InReady, 0);
        chk("idle_outvalid", OutValid, 0);
      end
      if (OutValid && OutReady) begin
        chk("parity", ^OutData, 0);
        if (exp_idx < FL) begin
          chk("stream_byte", OutData, exp_b[exp_idx]);
          got_b[exp_idx] <= OutData;
        end else begin
          chk("extra_byte", exp_idx, FL - 1);
        end
        if (Busy) begin
          exp_idx <= exp_idx + 1;
        end
      end
      prev_stall <= OutValid && !OutReady;
      prev_data  <= OutData;
    end
  end

  task automatic run_frame(input int pre_in, input logic [6:0] taps, input logic [6:0] seed,
                           input int n, input int stall_at, input int abort_at, output int acc);
    int         pre, nacc, idx, cyc, acks, nbytes;
    bit         done, aborted;
    logic [6:0] s, p;
    pre  = (pre_in < 10) ? 10 : ((pre_in > 26) ? 26 : pre_in);
    nacc = n;
    if (nacc > MM) nacc = MM;
    if (nacc > FL - pre) nacc = FL - pre;
    s = (seed == 7'h00) ? 7'h01 : seed;
    for (int k = 0; k < FL; k++) begin
      if ((k < pre) || (k >= pre + nacc)) p = 7'h20;
      else p = msg_b[k - pre][6:0];
      key_b[k] = s;
      exp_b[k] = enc(p, s);
      s = {s[5:0], ^(s & taps)};
    end
    @(posedge Clk); #2;
    Start = 1'b1; PreLen = pre_in[4:0]; TapPtrn = taps; LfsrInit = seed;
    OutReady = 1'b1; InValid = 1'b0; InLast = 1'b0;
    @(posedge Clk); #2;
    Start = 1'b0;
    @(negedge Clk);
    chk("start_busy", Busy, 1);
    chk("start_novalid", OutValid, 0);
    idx = 0; cyc = 0; acks = 0; nbytes = 0; done = 1'b0; aborted = 1'b0;
    while (!done && !aborted && (cyc < 400)) begin
      @(posedge Clk); #2;
      if ((abort_at >= 0) && (exp_idx >= abort_at)) begin
        Reset = 1'b0;
        #1;
        chk("abort_outvalid", OutValid, 0);
        chk("abort_outdata", OutData, 0);
        chk("abort_inready", InReady, 0);
        chk("abort_ack", Ack, 0);
        chk("abort_busy", Busy, 0);
        aborted = 1'b1;
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b1;
      end else begin
        InValid  = (idx < n);
        InData   = msg_b[(idx < 64) ? idx : 63];
        InLast   = (idx == n - 1);
        OutReady = !((stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3));
        Start    = (cyc == 20);
        @(negedge Clk);
        if (cyc == 0) chk("first_latency", OutValid, 1);
        if (InValid && InReady) idx++;
        if (Ack) begin
          acks++;
          nbytes = exp_idx;
          done = 1'b1;
        end
        cyc++;
      end
    end
    InValid = 1'b0; InLast = 1'b0; Start = 1'b0; OutReady = 1'b1;
    acc = idx;
    if (!aborted) begin
      chk("frame_done", done, 1);
      repeat (2) begin
        @(negedge Clk);
        if (Ack) acks++;
      end
      chk("ack_once", acks, 1);
      chk("bytes_out", nbytes, FL);
      chk("accepted", idx, nacc);
      chk("back_idle", Busy, 0);
    end
  endtask

  initial begin
    int  acc;
    bit  same;
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_outvalid", OutValid, 0);
    chk("rst_outdata", OutData, 0);
    chk("rst_inready", InReady, 0);
    chk("rst_ack", Ack, 0);
    chk("rst_busy", Busy, 0);
    Reset = 1'b1;

    msg_b[0] = 8'h41; msg_b[1] = 8'h6A; msg_b[2] = 8'h6F; msg_b[3] = 8'h6B;
    run_frame(10, 7'h69, 7'h01, 4, -1, -1, acc);
    chk("model_byte0", exp_b[0], 8'h21);
    chk("model_byte1", exp_b[1], 8'hA3);
    chk("dut_byte0", got_b[0], 8'h21);
    chk("dut_byte1", got_b[1], 8'hA3);
    chk("ajok_accepted", acc, 4);
    for (int k = 0; k < FL; k++) ref_b[k] = got_b[k];

    run_frame(10, 7'h69, 7'h00, 4, -1, -1, acc);
    same = 1'b1;
    for (int k = 0; k < FL; k++) if (got_b[k] !== ref_b[k]) same = 1'b0;
    chk("seed0_eq_seed1", same, 1);

    for (int i = 0; i < 20; i++) msg_b[i] = 8'hC1 + 8'(i);
    run_frame(5, 7'h60, 7'h2A, 20, 15, -1, acc);
    chk("lead_pad_5", lead_pads(), 10);

    run_frame(31, 7'h7B, 7'h55, 20, -1, -1, acc);
    chk("lead_pad_31", lead_pads(), 26);

    for (int i = 0; i < 54; i++) msg_b[i] = 8'h30 + 8'(i % 40);
    run_frame(26, 7'h48, 7'h11, 54, -1, -1, acc);
    chk("max_fit_accepted", acc, 38);

    msg_b[0] = 8'h41; msg_b[1] = 8'h6A; msg_b[2] = 8'h6F; msg_b[3] = 8'h6B;
    run_frame(10, 7'h69, 7'h01, 4, -1, 30, acc);
    run_frame(10, 7'h69, 7'h01, 4, -1, -1, acc);
    chk("restart_byte0", got_b[0], 8'h21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
